// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam int unsigned QDEPTH_DEF   = 2;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_fetch_queue.sv
// Small synchronous FIFO with push, pop and flush; flush wins over push and pop.
module mips_fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop & (cnt_q != '0);
  // A full queue still accepts a push when the head leaves the same cycle.
  assign do_push = push & (!full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_next(wr_q);
      if (do_pop)  rd_q <= ptr_next(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited imem reads, queues results for decode.
module mips_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned QDEPTH   = QDEPTH_DEF,
  parameter int unsigned CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  dcd_op,
  output logic [5:0]  dcd_funct2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             halted_q, halted_d;

  logic [CNT_W-1:0] q_count, tag_count;
  logic [CNT_W:0]   credit_used;
  logic [63:0]      q_rdata;
  fetch_entry_t     head;
  logic [31:0]      tag_pc;
  logic             halt_go, redirect_go, flush;
  logic             accept, rsp_take, keep, pop;

  assign halt_go     = halt & !halted_q & !rst;
  assign redirect_go = redirect_valid & !halt & !halted_q & !rst;
  assign flush       = halt_go | redirect_go;

  // Outstanding plus queued never exceeds QDEPTH, so every kept response has a free slot.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, q_count};
  assign imem_req_valid = !rst & !halted_q & !redirect_valid & !halt &
                          (credit_used < (CNT_W + 1)'(QDEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  assign rsp_take = imem_rsp_valid & (outstanding_q != '0);
  assign keep     = rsp_take & (drop_q == '0) & !flush & !halted_q & (tag_count != '0);

  assign inst_valid = (q_count != '0) & !halted_q & !rst;
  assign pop        = inst_valid & inst_ready;
  assign halted     = halted_q & !rst;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    halted_d      = halted_q | halt_go;

    if (redirect_go) begin
      pc_d = align_word(redirect_pc);
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end

    case ({accept, rsp_take})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Everything still in flight after this cycle's response belongs to the old stream.
    if (flush) begin
      drop_d = outstanding_q - CNT_W'(rsp_take);
    end else if (rsp_take && drop_q != '0) begin
      drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      halted_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      halted_q      <= halted_d;
    end
  end

  mips_fetch_queue #(
    .WIDTH (32),
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (accept),
    .wdata (pc_q),
    .pop   (keep),
    .rdata (tag_pc),
    .count (tag_count)
  );

  mips_fetch_queue #(
    .WIDTH (64),
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_inst_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (keep),
    .wdata ({imem_rsp_data, tag_pc}),
    .pop   (pop),
    .rdata (q_rdata),
    .count (q_count)
  );

  assign head       = fetch_entry_t'(q_rdata);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign dcd_op     = head.inst[OP_MSB:OP_LSB];
  assign dcd_funct2 = head.inst[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_mips_fetch.sv
// Scoreboard bench for mips_fetch: memory model with per-request stale flags feeds expected queue.
module tb_mips_fetch;

  localparam int QD = 2;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic [5:0]  dcd_op, dcd_funct2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt, halted;

  mips_fetch #(
    .RESET_PC (RST_PC),
    .QDEPTH   (QD),
    .CNT_W    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .dcd_op         (dcd_op),
    .dcd_funct2     (dcd_funct2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  mreq_t       mq[$];
  mreq_t       cur;
  exp_t        sb[$];
  int          lat, cyc, n_checks, n_errors, delivered, n_acc;
  bit          mem_rand, halted_m;
  logic [31:0] exp_pc, last_acc_addr, last_pop_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mq[i]) if (mq[i].stale) n++;
    if (imem_rsp_valid && cur.stale) n++;
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: compare outputs against the model, update the model, advance memory.
  task automatic tick();
    bit   flush, acc, pop;
    int   pend;
    exp_t e;
    #1;
    pend  = mq.size() + (imem_rsp_valid ? 1 : 0);
    flush = !rst && !halted_m && (halt || redirect_valid);
    check_eq("req_valid", {31'b0, imem_req_valid},
             {31'b0, !rst && !halted_m && !redirect_valid && !halt && (pend + sb.size() < QD)});
    check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, !rst && !halted_m && (sb.size() > 0)});
    check_eq("halted", {31'b0, halted}, {31'b0, !rst && halted_m});

    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      check_eq("req_addr", imem_req_addr, exp_pc);
      mq.push_back('{cyc + lat, imem_req_addr, 1'b0});
      last_acc_addr = imem_req_addr;
      exp_pc += 32'd4;
      n_acc++;
    end

    pop = inst_valid && inst_ready && !flush && !rst;
    if (pop) begin
      if (sb.size() == 0) begin
        check_eq("pop_unexpected", {31'b0, inst_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("inst_pc", inst_pc, e.pc);
        check_eq("inst", inst, e.data);
        check_eq("dcd_op", {26'b0, dcd_op}, {26'b0, e.data[31:26]});
        check_eq("dcd_funct2", {26'b0, dcd_funct2}, {26'b0, e.data[5:0]});
        last_pop_pc = inst_pc;
        delivered++;
      end
    end

    if (imem_rsp_valid && !rst && !flush && !cur.stale && !halted_m)
      sb.push_back('{cur.addr, memf(cur.addr)});

    if (flush) begin
      sb.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      if (halt) halted_m = 1'b1;
      else      exp_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    if (rst) begin
      sb.delete();
      mq.delete();
      exp_pc   = RST_PC;
      halted_m = 1'b0;
    end

    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      cur            = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(cur.addr);
    end
    if (mem_rand) imem_req_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    mq.delete();
    imem_rsp_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int guard, a0, d0;
    rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    cur = '{0, 32'h0, 1'b0};
    lat = 1; cyc = 0; n_checks = 0; n_errors = 0; delivered = 0; n_acc = 0;
    mem_rand = 1'b0; halted_m = 1'b0; exp_pc = RST_PC;
    last_acc_addr = '0; last_pop_pc = '0;

    // 1: sequential fetch, latency 1
    do_reset();
    check_eq("t1_first_addr", imem_req_addr, RST_PC);
    delivered = 0;
    repeat (30) tick();
    check_eq("t1_throughput", {31'b0, delivered >= 15}, 32'd1);

    // 2: decode stalled, then released with random memory readiness
    do_reset();
    inst_ready = 1'b0;
    repeat (10) tick();
    check_eq("t2_head_valid", {31'b0, inst_valid}, 32'd1);
    check_eq("t2_head_pc", inst_pc, RST_PC);
    check_eq("t2_head_inst", inst, memf(RST_PC));
    mem_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      inst_ready = 1'($urandom_range(0, 1));
      tick();
    end
    mem_rand = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (10) tick();

    // 3: redirect with two requests outstanding, latency 3
    do_reset();
    lat   = 3;
    guard = 0;
    while (dut.outstanding_q != 2'd2 && guard < 20) begin tick(); guard++; end
    check_eq("t3_two_out", {30'b0, dut.outstanding_q}, 32'd2);
    redirect_to(32'h0040_0102);
    a0 = n_acc; d0 = delivered; guard = 0;
    while (n_acc == a0 && guard < 20) begin tick(); guard++; end
    check_eq("t3_next_req", last_acc_addr, 32'h0040_0100);
    guard = 0;
    while (delivered == d0 && guard < 20) begin tick(); guard++; end
    check_eq("t3_first_pc", last_pop_pc, 32'h0040_0100);
    repeat (10) tick();

    // 4: redirect on the cycle a response arrives
    do_reset();
    lat   = 2;
    guard = 0;
    while (!imem_rsp_valid && guard < 20) begin tick(); guard++; end
    check_eq("t4_rsp_seen", {31'b0, imem_rsp_valid}, 32'd1);
    redirect_to(32'h0040_0200);
    check_eq("t4_drop_cnt", {30'b0, dut.drop_q}, stale_cnt());
    repeat (20) tick();

    // 5: halt together with redirect
    do_reset();
    lat = 1;
    repeat (5) tick();
    halt = 1'b1;
    redirect_to(32'h0000_1000);
    halt = 1'b0;
    check_eq("t5_halted", {31'b0, halted}, 32'd1);
    repeat (20) tick();
    check_eq("t5_still_halted", {31'b0, halted}, 32'd1);

    // 6: PC wrap, then reset mid-burst
    do_reset();
    redirect_to(32'hFFFF_FFFC);
    a0 = n_acc; guard = 0;
    while (n_acc < a0 + 2 && guard < 20) begin tick(); guard++; end
    check_eq("t6_wrap_addr", last_acc_addr, 32'h0000_0000);
    repeat (2) tick();
    do_reset();
    #1;
    check_eq("t6_rst_pc", imem_req_addr, RST_PC);
    check_eq("t6_rst_empty", {31'b0, inst_valid}, 32'd0);
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
